alu_issue_unit: RTL and testbench
=================================

# alu_issue_unit

Issue-side front end for the single-cycle `alu`. It accepts decoded RV32I opcode/funct fields plus operands over a valid/ready handshake, and maps them onto an `alu_sel_e` selection: it is the producer end of the `alu` select interface. It drives an internal `alu` instance and registers result, zero, branch-taken and illegal flags into a one-entry output stage with its own valid/ready handshake. It sits between the decode stage and writeback/branch resolution.

## Interface
Parameters:
- none; datapath fixed at 32 bits.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  request present
- `in_ready`  out  1  unit can accept request this cycle
- `opcode`  in  7  instruction opcode field
- `funct3`  in  3  instruction funct3 field
- `funct7b5`  in  1  bit 30 of instruction (funct7[5])
- `a`, `b`  in  32 each  operands (b is immediate for I-type/load/store)
- `out_valid`  out  1  result held
- `out_ready`  in  1  consumer takes result this cycle
- `out_result`  out  32  ALU result
- `out_zero`  out  1  ALU zero flag for held result
- `out_taken`  out  1  branch taken (branch ops only, else 0)
- `out_illegal`  out  1  unsupported opcode/funct combination
- `illegal_cnt`  out  8  saturating count of accepted illegal requests

## Operation
Decode, applied combinationally to the input fields:
- `0110011`, f3=000, b5=0 → ADD. f3=000, b5=1 → SUB. f3=110 → OR. f3=111 → AND. Any other f3 → illegal.
- `0010011`, f3=000 → ADD. f3=110 → OR. f3=111 → AND. `funct7b5` is ignored. Other f3 → illegal.
- `0000011` or `0100011` (load/store address), any f3 → ADD.
- `1100011`, f3=000 (BEQ) → SUB, taken = zero. f3=001 (BNE) → SUB, taken = !zero. Other f3 → illegal.
- Any other opcode → illegal.
- For an illegal request: sel drives a non-enumerated/default value, so the `alu` returns 0. `out_result` is 0, `out_zero` is 1, `out_taken` is 0, `out_illegal` is 1.

Arithmetic:
- Modulo 2^32 wrap. No overflow or carry reporting.

Output stage (one entry):
- Accept = `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational and allows a same-cycle drain and refill.
- On accept, the output registers load the decoded `alu` outputs and flags, and `out_valid` is set to 1.
- `out_valid && out_ready && !accept` → `out_valid` is cleared to 0.
- `out_valid && out_ready && accept` → the new result replaces the old one and `out_valid` stays 1.
- While `out_valid && !out_ready`: all `out_*` are held stable, `in_ready` is 0, and the input is ignored.
- `illegal_cnt` increments by 1 on each accepted illegal request and saturates at 255. It is never decremented.

## Timing
- Reset (`rst_n`=0 at a clock edge): `out_valid`=0, `out_result`=0, `out_zero`=0, `out_taken`=0, `out_illegal`=0, `illegal_cnt`=0. `in_ready` reads 1 once reset is released.
- Reset takes priority over accept. A held, undelivered result is discarded without being reported.
- Latency: request accepted at edge N → result visible with `out_valid`=1 after edge N.
- Throughput: 1 request/cycle while `out_ready`=1.
- Outputs are registered. The only combinational path input→output is `out_ready`→`in_ready`.
- `in_valid`=0 while `out_valid`=0 → no state change.

## Test plan
- Reset, then R-type ADD, a=0xFFFF_FFFF, b=1, `out_ready`=1 → one cycle later `out_result`=0, `out_zero`=1, `out_illegal`=0, `out_taken`=0.
- R-type SUB (b5=1), a=5, b=7 → `out_result`=0xFFFF_FFFE. I-type ORI with `funct7b5`=1, a=0xF0, b=0x0F → OR (not SUB), `out_result`=0xFF.
- BEQ a=b=0x1234 → `out_taken`=1. BNE a=b=0x1234 → `out_taken`=0. BNE a=1, b=2 → `out_taken`=1, `out_result`=0xFFFF_FFFF.
- Backpressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and outputs stable. Raise `out_ready` → same-cycle accept of the next request with no bubble. Back-to-back stream of 4 ops → 4 results in order.
- Opcode `0110111` and R-type f3=001 → `out_illegal`=1, `out_result`=0. Issue 260 illegal requests → `illegal_cnt` saturates at 255.
- Assert `rst_n`=0 while `out_valid`=1 and `out_ready`=0 → next cycle `out_valid`=0, `illegal_cnt`=0, and the held result is never delivered.

Source files
------------

// File: rtl/alu_issue_unit_if.sv
// alu_issue_unit_if: request and response bundle for the ALU issue unit.
//   Request : in_valid/in_ready handshake carrying opcode, funct3, funct7b5, a, b
//   Response: out_valid/out_ready handshake carrying out_result, out_zero,
//             out_taken and out_illegal, plus the illegal_cnt status counter
//   master  : the upstream/downstream side (decode + writeback)
//   slave   : the issue unit itself
interface alu_issue_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_taken;
  logic        out_illegal;
  logic [7:0]  illegal_cnt;

  modport master (
    output in_valid, opcode, funct3, funct7b5, a, b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_taken, out_illegal,
           illegal_cnt
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7b5, a, b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_taken, out_illegal,
           illegal_cnt
  );
endinterface

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: decodes RV32I opcode/funct fields into an ALU selection,
// runs a single-cycle ALU and registers the result into a one-entry output
// stage with its own valid/ready handshake.
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_issue_unit_if.slave (request in, result/flags out, illegal_cnt)
package alu_issue_unit_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3
  } alu_sel_e;
endpackage

// Single-cycle ALU; any non-enumerated selection yields 0.
module alu
  import alu_issue_unit_pkg::*;
(
  input  alu_sel_e    sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        zero
);
  always_comb begin
    y = '0;
    case (sel)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = '0;
    endcase
  end

  assign zero = (y == 32'd0);
endmodule

module alu_issue_unit
  import alu_issue_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_unit_if.slave   bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  alu_sel_e    sel;
  logic        illegal, is_beq, is_bne;
  logic [31:0] y;
  logic        zero, taken, accept;

  logic        out_valid_q, out_zero_q, out_taken_q, out_illegal_q;
  logic [31:0] out_result_q;
  logic [7:0]  illegal_cnt_q;

  always_comb begin
    sel     = ALU_ADD;
    illegal = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    case (bus.opcode)
      OP_R: case (bus.funct3)
        3'b000:  sel = bus.funct7b5 ? ALU_SUB : ALU_ADD;
        3'b110:  sel = ALU_OR;
        3'b111:  sel = ALU_AND;
        default: illegal = 1'b1;
      endcase
      OP_I: case (bus.funct3)
        3'b000:  sel = ALU_ADD;
        3'b110:  sel = ALU_OR;
        3'b111:  sel = ALU_AND;
        default: illegal = 1'b1;
      endcase
      OP_LOAD, OP_STORE: sel = ALU_ADD;
      OP_BRANCH: case (bus.funct3)
        3'b000:  begin sel = ALU_SUB; is_beq = 1'b1; end
        3'b001:  begin sel = ALU_SUB; is_bne = 1'b1; end
        default: illegal = 1'b1;
      endcase
      default: illegal = 1'b1;
    endcase
    // Out-of-range select forces the ALU to produce 0 (and so zero=1).
    if (illegal) sel = alu_sel_e'(3'b111);
  end

  alu u_alu (.sel(sel), .a(bus.a), .b(bus.b), .y(y), .zero(zero));

  assign taken  = (is_beq & zero) | (is_bne & ~zero);
  // Slot is free when empty or being drained this cycle.
  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_zero_q    <= 1'b0;
      out_taken_q   <= 1'b0;
      out_illegal_q <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      if (accept) begin
        out_valid_q   <= 1'b1;
        out_result_q  <= y;
        out_zero_q    <= zero;
        out_taken_q   <= taken;
        out_illegal_q <= illegal;
        if (illegal && illegal_cnt_q != 8'hFF)
          illegal_cnt_q <= illegal_cnt_q + 8'd1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_zero    = out_zero_q;
  assign bus.out_taken   = out_taken_q;
  assign bus.out_illegal = out_illegal_q;
  assign bus.illegal_cnt = illegal_cnt_q;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed self-checking bench for alu_issue_unit.
module tb_alu_issue_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_unit_if bus ();
  alu_issue_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                       input logic [31:0] av, input logic [31:0] bv);
    bus.opcode = op; bus.funct3 = f3; bus.funct7b5 = b5;
    bus.a = av; bus.b = bv; bus.in_valid = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drive(OP_R, 3'b000, 1'b0, 32'd1, 32'd1); bus.in_valid = 1'b0;
    step(); step();
    rst_n = 1'b1; #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.out_result); end
    n_cmp++; if ({bus.out_zero, bus.out_taken, bus.out_illegal} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {bus.out_zero, bus.out_taken, bus.out_illegal}); end
    n_cmp++; if (bus.illegal_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bus.illegal_cnt); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add();
    drive(OP_R, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1); step();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_result !== 32'd0) begin n_fail++; $display("FAIL add_result got %h want 0", bus.out_result); end
    n_cmp++; if ({bus.out_zero, bus.out_taken, bus.out_illegal} !== 3'b100) begin n_fail++; $display("FAIL add_flags got %b want 100", {bus.out_zero, bus.out_taken, bus.out_illegal}); end
  endtask

  task automatic test_sub_ori();
    drive(OP_R, 3'b000, 1'b1, 32'd5, 32'd7); step();
    n_cmp++; if (bus.out_result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_result got %h want fffffffe", bus.out_result); end
    n_cmp++; if (bus.out_zero !== 1'b0) begin n_fail++; $display("FAIL sub_zero got %b want 0", bus.out_zero); end
    drive(OP_I, 3'b110, 1'b1, 32'hF0, 32'h0F); step();
    n_cmp++; if (bus.out_result !== 32'hFF) begin n_fail++; $display("FAIL ori_result got %h want ff", bus.out_result); end
    drive(OP_R, 3'b111, 1'b0, 32'hF0F0, 32'h3C3C); step();
    n_cmp++; if (bus.out_result !== 32'h3030) begin n_fail++; $display("FAIL and_result got %h want 3030", bus.out_result); end
    drive(OP_LD, 3'b010, 1'b1, 32'h100, 32'h4); step();
    n_cmp++; if (bus.out_result !== 32'h104) begin n_fail++; $display("FAIL load_addr got %h want 104", bus.out_result); end
  endtask

  task automatic test_branch();
    drive(OP_BR, 3'b000, 1'b0, 32'h1234, 32'h1234); step();
    n_cmp++; if (bus.out_taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken got %b want 1", bus.out_taken); end
    drive(OP_BR, 3'b001, 1'b0, 32'h1234, 32'h1234); step();
    n_cmp++; if (bus.out_taken !== 1'b0) begin n_fail++; $display("FAIL bne_eq_taken got %b want 0", bus.out_taken); end
    drive(OP_BR, 3'b001, 1'b0, 32'd1, 32'd2); step();
    n_cmp++; if (bus.out_taken !== 1'b1) begin n_fail++; $display("FAIL bne_ne_taken got %b want 1", bus.out_taken); end
    n_cmp++; if (bus.out_result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL bne_result got %h want ffffffff", bus.out_result); end
    drive(OP_R, 3'b000, 1'b0, 32'd0, 32'd0); step();
    n_cmp++; if (bus.out_taken !== 1'b0) begin n_fail++; $display("FAIL add_not_branch_taken got %b want 0", bus.out_taken); end
  endtask

  task automatic test_illegal();
    drive(OP_LUI, 3'b000, 1'b0, 32'h55, 32'h66); step();
    n_cmp++; if ({bus.out_zero, bus.out_taken, bus.out_illegal} !== 3'b101) begin n_fail++; $display("FAIL lui_flags got %b want 101", {bus.out_zero, bus.out_taken, bus.out_illegal}); end
    n_cmp++; if (bus.out_result !== 32'd0) begin n_fail++; $display("FAIL lui_result got %h want 0", bus.out_result); end
    n_cmp++; if (bus.illegal_cnt !== 8'd1) begin n_fail++; $display("FAIL lui_cnt got %0d want 1", bus.illegal_cnt); end
    drive(OP_R, 3'b001, 1'b0, 32'h7, 32'h1); step();
    n_cmp++; if (bus.out_illegal !== 1'b1 || bus.out_result !== 32'd0) begin n_fail++; $display("FAIL r_f3_001 got ill=%b res=%h want ill=1 res=0", bus.out_illegal, bus.out_result); end
    drive(OP_BR, 3'b100, 1'b0, 32'h3, 32'h3); step();
    n_cmp++; if (bus.out_illegal !== 1'b1 || bus.out_taken !== 1'b0) begin n_fail++; $display("FAIL blt_illegal got ill=%b tk=%b want ill=1 tk=0", bus.out_illegal, bus.out_taken); end
    n_cmp++; if (bus.illegal_cnt !== 8'd3) begin n_fail++; $display("FAIL ill_cnt3 got %0d want 3", bus.illegal_cnt); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b1;
    drive(OP_R, 3'b000, 1'b0, 32'd10, 32'd20); step();
    bus.out_ready = 1'b0;
    drive(OP_R, 3'b000, 1'b0, 32'd1, 32'd1); #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_lo got %b want 0", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== 32'd30)
        begin n_fail++; $display("FAIL bp_hold%0d got rdy=%b vld=%b res=%0d want rdy=0 vld=1 res=30", i, bus.in_ready, bus.out_valid, bus.out_result); end
    end
    bus.out_ready = 1'b1; #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_hi got %b want 1", bus.in_ready); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd2) begin n_fail++; $display("FAIL bp_refill got vld=%b res=%0d want vld=1 res=2", bus.out_valid, bus.out_result); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av [4] = '{32'd100, 32'd9, 32'hFF00, 32'hA0};
    logic [31:0] bv [4] = '{32'd23, 32'd4, 32'h0FF0, 32'h0B};
    logic [2:0]  f3 [4] = '{3'b000, 3'b000, 3'b111, 3'b110};
    logic        b5 [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ex [4] = '{32'd123, 32'd5, 32'h0F00, 32'hAB};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(OP_R, f3[i], b5[i], av[i], bv[i]); step();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== ex[i])
        begin n_fail++; $display("FAIL b2b%0d got vld=%b res=%h want vld=1 res=%h", i, bus.out_valid, bus.out_result, ex[i]); end
    end
    bus.in_valid = 1'b0; step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_saturate();
    int exp_cnt;
    exp_cnt = 3;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      drive(OP_LUI, 3'b000, 1'b0, 32'd0, 32'd0); step();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      n_cmp++; if (bus.illegal_cnt !== exp_cnt[7:0]) begin n_fail++; $display("FAIL sat_cnt%0d got %0d want %0d", i, bus.illegal_cnt, exp_cnt); end
    end
    bus.in_valid = 1'b0; step();
    n_cmp++; if (bus.illegal_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_final got %0d want 255", bus.illegal_cnt); end
  endtask

  task automatic test_reset_discard();
    bus.out_ready = 1'b1;
    drive(OP_R, 3'b000, 1'b0, 32'd3, 32'd4); step();
    bus.out_ready = 1'b0; bus.in_valid = 1'b0; step();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd7) begin n_fail++; $display("FAIL rd_held got vld=%b res=%0d want vld=1 res=7", bus.out_valid, bus.out_result); end
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(OP_R, 3'b000, 1'b0, 32'd8, 32'd8); step();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.illegal_cnt !== 8'd0 || bus.out_result !== 32'd0)
      begin n_fail++; $display("FAIL rd_reset got vld=%b cnt=%0d res=%0d want vld=0 cnt=0 res=0", bus.out_valid, bus.illegal_cnt, bus.out_result); end
    bus.in_valid = 1'b0; rst_n = 1'b1; step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_after got %b want 0", bus.out_valid); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.a = '0; bus.b = '0;
    test_reset();
    test_add();
    test_sub_ori();
    test_branch();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_saturate();
    test_reset_discard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
